// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit path.
// The host-to-device frame is start 0, eight data bits LSB first,
// odd parity, stop 1, then an acknowledge bit driven by the device.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  // Common keyboard commands.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Device acknowledge byte; the receive path handles it.
  localparam logic [7:0] RESP_ACK = 8'hFA;

  // Falling-edge counts inside XFER: edges 1..8 carry data,
  // edge 9 carries parity, and edge 10 releases the line for the stop bit.
  localparam logic [3:0] EDGE_PARITY = 4'd8;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronizer for one PS/2 line plus a
// falling-edge flag. Every flop resets to 1 because an idle, released
// line reads high, so reset never produces a false edge.
module ps2_sync_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Two synchronizer stages, plus a copy of the last synchronized level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  // The user of this flag registers its response, so a bit change
  // lands three clocks after the pin falls.
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// It holds PS2_CLK low to inhibit the device, then drives the request
// (data low with the clock released). After that it shifts out the frame
// on the device's falling clock edges. Both lines are open-drain: each
// one is either driven low or released.
// Optional feature: define PS2_HOST_TX_ACK_CHECK_EN so that an ack bit of 1
// ends the frame with error. Without it, the ack sample is ignored.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5500,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_valid,
  output logic       send_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

  tx_state_t        state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             parity, parity_n;
  logic             clk_oe, clk_oe_n;
  logic             dat_oe, dat_oe_n;
  logic             send_ready_n, busy_n, done_n, error_n;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
  logic             ack_bit, ack_bit_n;
`endif

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall_unused;

  ps2_sync_edge u_sync_clk (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (PS2_CLK),
    .level    (clk_lvl),
    .fall     (clk_fall)
  );

  ps2_sync_edge u_sync_dat (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (PS2_DAT),
    .level    (dat_lvl),
    .fall     (dat_fall_unused)
  );

  // Open-drain drivers: a line is either pulled low or released.
  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  // State register and all registered outputs and line enables.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      inh_cnt    <= '0;
      tmo_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity     <= 1'b0;
      clk_oe     <= 1'b0;
      dat_oe     <= 1'b0;
      send_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
      ack_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      inh_cnt    <= inh_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      parity     <= parity_n;
      clk_oe     <= clk_oe_n;
      dat_oe     <= dat_oe_n;
      send_ready <= send_ready_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
      ack_bit    <= ack_bit_n;
`endif
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    tmo_cnt_n = tmo_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    parity_n  = parity;
    clk_oe_n  = clk_oe;
    dat_oe_n  = dat_oe;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = 1'b0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
    ack_bit_n = ack_bit;
`endif

    unique case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (send_valid && send_ready) begin
          shreg_n   = send_data;
          parity_n  = odd_parity(send_data);
          inh_cnt_n = '0;
          clk_oe_n  = 1'b1;
          busy_n    = 1'b1;
          state_n   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          // Release the clock and drive data low in the same edge; together
          // these form the request-to-send.
          clk_oe_n  = 1'b0;
          dat_oe_n  = 1'b1;
          tmo_cnt_n = '0;
          state_n   = START;
        end else begin
          inh_cnt_n = inh_cnt + INH_W'(1);
        end
      end

      START: begin
        bit_cnt_n = '0;
        state_n   = XFER;
      end

      XFER: begin
        if (clk_fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < EDGE_PARITY) begin
            dat_oe_n = ~shreg[0];
            shreg_n  = {1'b0, shreg[7:1]};
          end else if (bit_cnt == EDGE_PARITY) begin
            dat_oe_n = ~parity;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end
        end
      end

      ACK: begin
        if (clk_fall) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
          ack_bit_n = dat_lvl;
`endif
          state_n = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
          done_n  = ~ack_bit;
          error_n = ack_bit;
`else
          done_n  = 1'b1;
`endif
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase

    // The timeout overrides any transition the case made in this cycle.
    // It runs from the START cycle until the ack edge.
    if (state == START || state == XFER || state == ACK) begin
      if (tmo_cnt == TMO_LAST) begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        busy_n   = 1'b0;
        error_n  = 1'b1;
        state_n  = IDLE;
      end else begin
        tmo_cnt_n = tmo_cnt + TMO_W'(1);
      end
    end

    // Ready reopens one cycle after the done/error pulse.
    send_ready_n = (state == IDLE) && (state_n == IDLE);
  end

endmodule
